seq_pattern_tx: RTL and testbench

Serial pattern transmitter that generates framed bitstreams for the team's sequence-detector blocks. On a start handshake it shifts out N copies of a fixed 7-bit pattern (default 1101100), MSB first, one bit per clock, with a programmable number of filler bits between copies. Used as the stimulus and loopback source for the detector, and as a standalone serial test-pattern generator.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_lfsr7.sv | 24 ++
 rtl/seq_pattern_tx.sv | 148 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the serial pattern transmitter and its LFSR filler.
package seq_pkg;

  localparam int          PAT_LEN             = 7;
  localparam logic [6:0]  SEQ_PATTERN_DEFAULT = 7'b1101100;
  localparam logic [2:0]  IDX_FIRST           = 3'd6;
  localparam logic [2:0]  IDX_LAST            = 3'd0;

  // x^7 + x^6 + 1: feedback taps on bits 6 and 5 of a left-shifting register
  localparam logic [6:0]  LFSR_SEED           = 7'h5A;
  localparam logic [6:0]  LFSR_TAPS           = 7'b1100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

  function automatic logic lfsr_feedback(input logic [6:0] q, input logic [6:0] taps);
    return ^(q & taps);
  endfunction

endpackage

// File: rtl/seq_lfsr7.sv
// 7-bit Fibonacci LFSR with enable; shifts left and exposes bit 0 as the filler bit.
module seq_lfsr7
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic fill
);

  logic [6:0] q_r;

  // Shift register; only reset reseeds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= LFSR_SEED;
    end else if (en) begin
      q_r <= {q_r[5:0], lfsr_feedback(q_r, LFSR_TAPS)};
    end
  end

  assign fill = q_r[0];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: N framed copies of PATTERN with programmable filler gaps.
// Build option SEQ_TX_LFSR_FILL_EN selects LFSR filler bits instead of constant zeros.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter logic [6:0] PATTERN = SEQ_PATTERN_DEFAULT,
  parameter int         CNT_W   = 8,
  parameter int         GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  tx_state_e        state_r, state_s;
  logic [2:0]       idx_r, idx_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [GAP_W-1:0] gap_len_r, gap_len_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;

  logic             fill_s;
  logic             x_s;
  logic             accept_s;

  assign accept_s = start_i && ready_o;

`ifdef SEQ_TX_LFSR_FILL_EN
  logic fill_en_s;

  // The LFSR steps on every edge that launches a gap bit, so each gap bit is a fresh value
  assign fill_en_s = (state_s == ST_GAP);

  seq_lfsr7 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fill_en_s),
    .fill  (fill_s)
  );
`else
  assign fill_s = 1'b0;
`endif

  // Next-state logic; state/idx describe the bit that will be on x_o after the edge
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    rem_s     = rem_r;
    gap_len_s = gap_len_r;
    gap_cnt_s = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          gap_len_s = gap_i;
          if (count_i == CNT_ZERO) begin
            state_s = ST_DONE;
            rem_s   = CNT_ZERO;
          end else begin
            state_s = ST_SEND;
            idx_s   = IDX_FIRST;
            rem_s   = count_i - CNT_ONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (idx_r != IDX_LAST) begin
          idx_s = idx_r - 3'd1;
        end else if (rem_r != CNT_ZERO) begin
          rem_s = rem_r - CNT_ONE;
          if (gap_len_r != GAP_ZERO) begin
            state_s   = ST_GAP;
            gap_cnt_s = gap_len_r - GAP_ONE;
          end else begin
            state_s = ST_SEND;
            idx_s   = IDX_FIRST;
          end
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r != GAP_ZERO) begin
          gap_cnt_s = gap_cnt_r - GAP_ONE;
        end else begin
          state_s = ST_SEND;
          idx_s   = IDX_FIRST;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Serial data bit decoded from the upcoming state
  always_comb begin
    x_s = 1'b0;
    case (state_s)
      ST_SEND: x_s = PATTERN[idx_s];
      ST_GAP:  x_s = fill_s;
      default: x_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 3'd0;
      rem_r     <= CNT_ZERO;
      gap_len_r <= GAP_ZERO;
      gap_cnt_r <= GAP_ZERO;
      ready_o   <= 1'b1;
      x_o       <= 1'b0;
      x_valid_o <= 1'b0;
      frame_o   <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      rem_r     <= rem_s;
      gap_len_r <= gap_len_s;
      gap_cnt_r <= gap_cnt_s;
      ready_o   <= (state_s == ST_IDLE);
      x_o       <= x_s;
      x_valid_o <= (state_s == ST_SEND) || (state_s == ST_GAP);
      frame_o   <= (state_s == ST_SEND) && (idx_s == IDX_LAST);
      done_o    <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed, table-driven bench for seq_pattern_tx with a loopback 1101100 detector.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] count_i;
  logic [3:0] gap_i;
  logic       ready_o, x_o, x_valid_o, frame_o, done_o;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PATTERN (7'b1101100),
    .CNT_W   (8),
    .GAP_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .count_i   (count_i),
    .gap_i     (gap_i),
    .ready_o   (ready_o),
    .x_o       (x_o),
    .x_valid_o (x_valid_o),
    .frame_o   (frame_o),
    .done_o    (done_o)
  );

  typedef struct {
    logic       start;
    logic [7:0] count;
    logic [3:0] gap;
    logic       ready;
    logic       x;
    logic       valid;
    logic       frame;
    logic       done;
  } vec_t;

  vec_t       vq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [6:0] ref_lfsr = 7'h5A;
  logic [6:0] det_r    = 7'd0;
  int         det_hits = 0;

  // Reference filler stream: bit 0 of x^7+x^6+1 LFSR seeded 0x5A, one step per gap bit
  function automatic logic ref_fill();
    logic b;
`ifdef SEQ_TX_LFSR_FILL_EN
    b = ref_lfsr[0];
    ref_lfsr = {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
`else
    b = 1'b0;
`endif
    return b;
  endfunction

  function automatic vec_t mk(input logic st, input logic [7:0] cnt, input logic [3:0] gp,
                              input logic rdy, input logic x, input logic vld,
                              input logic frm, input logic dn);
    vec_t v;
    v.start = st;  v.count = cnt; v.gap = gp;
    v.ready = rdy; v.x = x; v.valid = vld; v.frame = frm; v.done = dn;
    return v;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) vq.push_back(mk(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Expected trace of one transfer, cycle c counted from the accepting edge
  task automatic push_txn(input logic [7:0] cnt, input logic [3:0] gp,
                          input int ign_cyc, input int max_cyc);
    logic [6:0] pat;
    int         p, last, endc, off;
    vec_t       v;
    pat  = 7'b1101100;
    p    = 7 + int'(gp);
    last = (cnt == 8'd0) ? 0 : 7 + (int'(cnt) - 1) * p;
    endc = last + 2;
    if (max_cyc > 0 && max_cyc < endc) endc = max_cyc;
    for (int c = 1; c <= endc; c++) begin
      v = mk((c == 1) || (c == ign_cyc), (c == ign_cyc) ? 8'd5 : cnt,
             (c == ign_cyc) ? 4'd9 : gp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (c <= last) begin
        off     = (c - 1) % p;
        v.valid = 1'b1;
        if (off < 7) begin
          v.x     = pat[6 - off];
          v.frame = (off == 6);
        end else begin
          v.x = ref_fill();
        end
      end else if (c == last + 1) begin
        v.done = 1'b1;
      end else begin
        v.ready = 1'b1;
      end
      vq.push_back(v);
    end
  endtask

  task automatic run_vecs(input string name, input bit loop_chk);
    logic [3:0] got, exp;
    logic       hit;
    for (int i = 0; i < vq.size(); i++) begin
      start_i = vq[i].start;
      count_i = vq[i].count;
      gap_i   = vq[i].gap;
      @(posedge clk);
      @(negedge clk);
      got = {ready_o, x_valid_o, frame_o, done_o};
      exp = {vq[i].ready, vq[i].valid, vq[i].frame, vq[i].done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s[%0d] ctrl {ready,valid,frame,done} got=%b exp=%b", name, i, got, exp);
      end
      if (vq[i].valid || vq[i].ready) begin
        checks++;
        if (x_o !== vq[i].x) begin
          failures++;
          $display("FAIL %s[%0d] x_o got=%b exp=%b", name, i, x_o, vq[i].x);
        end
      end
      det_r = {det_r[5:0], x_o};
      hit   = (det_r == 7'b1101100);
      if (hit) det_hits++;
      if (loop_chk) begin
        checks++;
        if (hit !== frame_o) begin
          failures++;
          $display("FAIL %s[%0d] detector hit=%b frame_o=%b", name, i, hit, frame_o);
        end
      end
    end
    vq.delete();
    start_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({ready_o, x_o, x_valid_o, frame_o, done_o} !== 5'b10000) begin
      failures++;
      $display("FAIL %s outputs got=%b exp=10000", name,
               {ready_o, x_o, x_valid_o, frame_o, done_o});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_hold");
    rst_n    = 1'b1;
    ref_lfsr = 7'h5A;
    det_r    = 7'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    start_i = 1'b0;
    count_i = 8'd0;
    gap_i   = 4'd0;
    do_reset();

    push_idle(20);
    run_vecs("idle20", 1'b0);

    push_txn(8'd1, 4'd0, 0, 0);
    push_idle(2);
    run_vecs("c1g0", 1'b0);

    push_txn(8'd3, 4'd2, 0, 0);
    push_idle(2);
    run_vecs("c3g2", 1'b0);

    push_txn(8'd0, 4'd5, 0, 0);
    push_idle(2);
    run_vecs("c0", 1'b0);

    // Second start mid-frame with different count/gap must not change the transfer
    push_txn(8'd2, 4'd0, 3, 0);
    push_idle(3);
    run_vecs("ignore_start", 1'b0);

    // Abort a count=2 transfer during cycle 4
    push_txn(8'd2, 4'd1, 0, 4);
    run_vecs("abort_pre", 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_async");
    @(negedge clk);
    check_reset_vals("reset_held");
    rst_n    = 1'b1;
    ref_lfsr = 7'h5A;
    det_r    = 7'd0;
    push_idle(6);
    run_vecs("abort_post", 1'b0);
    push_txn(8'd1, 4'd0, 0, 0);
    push_idle(1);
    run_vecs("after_abort", 1'b0);

    do_reset();
    det_hits = 0;
    push_txn(8'd5, 4'd3, 0, 0);
    push_idle(2);
    run_vecs("loopback", 1'b1);
    checks++;
    if (det_hits != 5) begin
      failures++;
      $display("FAIL loopback_hits got=%0d exp=5", det_hits);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
